// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage MIPS core: register indices, PC source
// encoding, hazard controller state and the bundle of latch controls.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hazard_state_t;

    // Enables and synchronous clears for the PC and the four pipeline latches
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t CTRL_ADVANCE = 8'b11111_000;
    localparam latch_ctrl_t CTRL_FREEZE  = 8'b00000_000;

endpackage

// File: rtl/hazard_perf.sv
// Saturating stall and control-flow flush counters for the hazard controller.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count events, sticking at all-ones rather than wrapping
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Hazard and stall controller: sole producer of PC/latch enables and flushes.
// Handles load-use bubbles, EX-resolved control flow, data-cache freezes,
// fetch misses and halt draining.
// Optional build macro HAZARD_PERF_EN adds stall_cnt/flush_cnt counters.
module hazard_control
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       dREN_MEM,
    input  logic       dWEN_MEM,
    input  regbits_t   rs_ID,
    input  regbits_t   rt_ID,
    input  logic       memtoReg_EX,
    input  regbits_t   wsel_EX,
    input  logic [1:0] PC_Src_EX,
    input  logic       halt_EX,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    hazard_state_t    state, state_n;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_n;
    latch_ctrl_t      ctrl;
    logic             mem_wait;
    logic             ctrl_flow;
    logic             load_use;

    // Raw hazard conditions from the current pipeline contents
    always_comb begin
        mem_wait  = (dREN_MEM | dWEN_MEM) & ~dhit;
        ctrl_flow = (PC_Src_EX != PCSRC_SEQ);
        // $0 is never really written, so a load targeting it cannot hazard
        load_use  = memtoReg_EX && (wsel_EX != '0) &&
                    ((wsel_EX == rs_ID) || (wsel_EX == rt_ID));
    end

    // Next-state and latch-control decode, priority ordered within each state
    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        ctrl        = CTRL_ADVANCE;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    ctrl    = CTRL_FREEZE;
                    state_n = MEMWAIT;
                end else if (halt_EX) begin
                    // Kill everything younger than the halt, let EX/MEM/WB retire
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    drain_cnt_n     = DRAIN_LOAD;
                    state_n         = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                end else if (ctrl_flow) begin
                    // Redirect the PC once the target fetch can proceed
                    ctrl.pc_en      = ihit;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and ID, push a bubble into EX
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_en    = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end else if (!ihit) begin
                    // No valid fetch yet: feed a bubble into ID
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                end
            end
            MEMWAIT: begin
                if (dhit) begin
                    // Release the freeze; a branch held in EX resolves now
                    state_n = RUN;
                    if (ctrl_flow) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end
                end else begin
                    ctrl = CTRL_FREEZE;
                end
            end
            DRAIN: begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                if (mem_wait) begin
                    // Retiring memory op stalled: hold the tail and the count
                    ctrl.exmem_en = 1'b0;
                    ctrl.memwb_en = 1'b0;
                end else if (drain_cnt <= CNT_ONE) begin
                    drain_cnt_n = '0;
                    state_n     = HALTED;
                end else begin
                    drain_cnt_n = drain_cnt - CNT_ONE;
                end
            end
            HALTED: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl    = CTRL_FREEZE;
                state_n = RUN;
            end
        endcase
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;

    // Controller state, drain count and the registered halted flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            halted    <= (state_n == HALTED);
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // A control-flow flush is taken either in RUN or on release from MEMWAIT
    always_comb begin
        stall_inc = !ctrl.pc_en && (state != HALTED);
        flush_inc = ctrl_flow &&
                    (((state == RUN) && !mem_wait && !halt_EX) ||
                     ((state == MEMWAIT) && dhit));
    end

    hazard_perf u_perf (
        .CLK       (CLK),
        .nRST      (nRST),
        .stall_inc (stall_inc),
        .flush_inc (flush_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control (DRAIN_CYCLES = 2).
module tb_hazard_control;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, dREN_MEM, dWEN_MEM;
    logic [4:0] rs_ID, rt_ID, wsel_EX;
    logic       memtoReg_EX, halt_EX;
    logic [1:0] PC_Src_EX;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_control #(.DRAIN_CYCLES(2)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dREN_MEM    (dREN_MEM),
        .dWEN_MEM    (dWEN_MEM),
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .memtoReg_EX (memtoReg_EX),
        .wsel_EX     (wsel_EX),
        .PC_Src_EX   (PC_Src_EX),
        .halt_EX     (halt_EX),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
`ifdef HAZARD_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    // Output vector: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, halted}
    localparam logic [8:0] E_ALL1  = 9'b11111_000_0;
    localparam logic [8:0] E_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] E_LU    = 9'b00111_010_0;
    localparam logic [8:0] E_BR    = 9'b11111_110_0;
    localparam logic [8:0] E_BRNI  = 9'b01111_110_0;
    localparam logic [8:0] E_FM    = 9'b01111_100_0;
    localparam logic [8:0] E_HLT   = 9'b00011_110_0;
    localparam logic [8:0] E_DRW   = 9'b00000_110_0;
    localparam logic [8:0] E_HD    = 9'b00000_000_1;
    localparam logic [8:0] M_ALL   = 9'b11111_111_1;
    localparam logic [8:0] M_HLT   = 9'b10011_110_1;
    localparam logic [8:0] M_HD    = 9'b11111_000_1;

    typedef struct {
        logic       ih, dh, dr, dw;
        logic [4:0] rs, rt;
        logic       mtr;
        logic [4:0] ws;
        logic [1:0] pcs;
        logic       hlt;
        logic [8:0] expv, mask;
    } step_t;

    step_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic step_t mk(input logic ih, dh, dr, dw,
                                 input logic [4:0] rs, rt, input logic mtr,
                                 input logic [4:0] ws, input logic [1:0] pcs,
                                 input logic hlt, input logic [8:0] expv, mask);
        step_t s;
        s.ih = ih; s.dh = dh; s.dr = dr; s.dw = dw;
        s.rs = rs; s.rt = rt; s.mtr = mtr; s.ws = ws;
        s.pcs = pcs; s.hlt = hlt; s.expv = expv; s.mask = mask;
        return s;
    endfunction

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, halted};
    endfunction

    task automatic set_quiet();
        ihit = 1'b1; dhit = 1'b0; dREN_MEM = 1'b0; dWEN_MEM = 1'b0;
        rs_ID = '0; rt_ID = '0; memtoReg_EX = 1'b0; wsel_EX = '0;
        PC_Src_EX = 2'b00; halt_EX = 1'b0;
    endtask

    task automatic drive_step(input step_t s);
        @(posedge CLK); #1;
        ihit = s.ih; dhit = s.dh; dREN_MEM = s.dr; dWEN_MEM = s.dw;
        rs_ID = s.rs; rt_ID = s.rt; memtoReg_EX = s.mtr; wsel_EX = s.ws;
        PC_Src_EX = s.pcs; halt_EX = s.hlt;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0;
        set_quiet();
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        // Under reset: outputs still follow RUN decode of the inputs
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(1,0,0,0, 7,0,1,7, 2'b00,0, E_LU,   M_ALL));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,1, E_HLT,  M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL reset[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
`ifdef HAZARD_PERF_EN
        n_total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        else
            n_pass++;
`endif
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_load_use();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,0,0, 3,0,1,3, 2'b00,0, E_LU,   M_ALL));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(1,0,0,0, 9,3,1,3, 2'b00,0, E_LU,   M_ALL));
        q.push_back(mk(0,0,0,0, 3,0,1,3, 2'b00,0, E_LU,   M_ALL));
        q.push_back(mk(1,0,0,0, 4,5,1,3, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(1,0,0,0, 3,3,0,3, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(0,0,0,0, 0,0,0,0, 2'b00,0, E_FM,   M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL load_use[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_reg_zero();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,0,0, 0,0,1,0, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(1,0,0,0, 5,0,1,0, 2'b00,0, E_ALL1, M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL reg_zero[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_branch();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b01,0, E_BR,   M_ALL));
        q.push_back(mk(0,0,0,0, 0,0,0,0, 2'b10,0, E_BRNI, M_ALL));
        q.push_back(mk(1,0,0,0, 3,0,1,3, 2'b11,0, E_BR,   M_ALL));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL branch[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
`ifdef HAZARD_PERF_EN
            if (i < 2) begin
                n_total++;
                if (flush_cnt !== 32'(i))
                    $display("FAIL branch_flush_cnt[%0d]: got %0d expected %0d", i, flush_cnt, i);
                else
                    n_pass++;
            end
`endif
        end
    endtask

    task automatic test_data_miss();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_FRZ,  M_ALL));
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_FRZ,  M_ALL));
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_FRZ,  M_ALL));
        q.push_back(mk(1,1,1,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        // A load-use decode here shows the controller is back in RUN
        q.push_back(mk(1,0,0,0, 3,0,1,3, 2'b00,0, E_LU,   M_ALL));
        // Store miss together with a taken branch: freeze, then branch on dhit
        q.push_back(mk(1,0,0,1, 0,0,0,0, 2'b01,0, E_FRZ,  M_ALL));
        q.push_back(mk(1,0,0,1, 0,0,0,0, 2'b01,0, E_FRZ,  M_ALL));
        q.push_back(mk(1,1,0,1, 0,0,0,0, 2'b01,0, E_BR,   M_ALL));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL data_miss[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_halt();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,1, E_HLT, M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_HLT, M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_HLT, M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_HD,  M_HD));
        q.push_back(mk(1,0,0,0, 3,0,1,3, 2'b01,0, E_HD,  M_HD));
        q.push_back(mk(0,1,1,0, 0,0,0,0, 2'b00,1, E_HD,  M_HD));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL halt[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_drain_memwait();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,1, E_HLT, M_HLT));
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_DRW, M_HLT));
        q.push_back(mk(1,1,1,0, 0,0,0,0, 2'b00,0, E_HLT, M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_HLT, M_HLT));
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_HD,  M_HD));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL drain_memwait[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_midstall();
        step_t q[$];
        step_t e;
        logic [8:0] got;
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_FRZ, M_ALL));
        q.push_back(mk(1,0,1,0, 0,0,0,0, 2'b00,0, E_FRZ, M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL reset_mid_pre[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
        // Asynchronous reset between edges while in MEMWAIT
        @(posedge CLK); #1;
        nRST = 1'b0;
        set_quiet();
        #2;
        got = outs();
        n_total++;
        if (got !== E_ALL1)
            $display("FAIL reset_mid_async: got %b expected %b", got, E_ALL1);
        else
            n_pass++;
`ifdef HAZARD_PERF_EN
        n_total++;
        if (stall_cnt !== 32'd0)
            $display("FAIL reset_mid_stall_cnt: got %0d expected 0", stall_cnt);
        else
            n_pass++;
`endif
        @(posedge CLK); #1;
        nRST = 1'b1;
        q.delete();
        q.push_back(mk(1,0,0,0, 0,0,0,0, 2'b00,0, E_ALL1, M_ALL));
        q.push_back(mk(1,0,0,0, 3,0,1,3, 2'b00,0, E_LU,   M_ALL));
        foreach (q[i]) begin
            drive_step(q[i]);
            sb.push_back(q[i]);
            @(negedge CLK);
            e = sb.pop_front();
            got = outs();
            n_total++;
            if ((got & e.mask) !== (e.expv & e.mask))
                $display("FAIL reset_mid_post[%0d]: got %b expected %b mask %b", i, got, e.expv, e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_halted();
        logic [8:0] got;
        @(posedge CLK); #1;
        nRST = 1'b0;
        set_quiet();
        @(negedge CLK);
        got = outs();
        n_total++;
        if (got !== E_ALL1)
            $display("FAIL reset_halted: got %b expected %b", got, E_ALL1);
        else
            n_pass++;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        set_quiet();
        test_reset();
        test_load_use();
        test_reg_zero();
        do_reset();
        test_branch();
        test_data_miss();
        test_halt();
        test_reset_halted();
        test_drain_memwait();
        do_reset();
        test_reset_midstall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
